// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

   // Controller states, in the order an instruction passes through them
   typedef enum logic [2:0] {
      FETCH   = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      TRAP    = 3'd5
   } state_t;

   // Major opcodes of the supported subset
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct3 values
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // funct7 values that distinguish add from sub
   localparam logic [6:0] F7_ADD = 7'h00;
   localparam logic [6:0] F7_SUB = 7'h20;

   // ImmSrc encodings seen by the immediate generator
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   // One-hot-ish decode of the latched instruction
   typedef struct packed {
      logic is_r;
      logic is_sub;
      logic is_addi;
      logic is_lw;
      logic is_sw;
      logic is_beq;
      logic is_bne;
      logic legal;
   } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction word into control flags.
// Latency: 0 cycles (pure logic; registered only through the IR copy upstream).
// Backpressure: none.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0] ir_i,
   output dec_t        dec_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   // Register specifiers and immediate bits are datapath concerns only
   logic       unused_fields;

   assign opcode        = ir_i[6:0];
   assign funct3        = ir_i[14:12];
   assign funct7        = ir_i[31:25];
   assign unused_fields = ^{ir_i[24:15], ir_i[11:7]};

   // Classify the instruction; anything not matched falls out as illegal
   always_comb begin
      dec_o         = '0;
      dec_o.is_r    = (opcode == OP_R) && (funct3 == F3_ADD) &&
                      ((funct7 == F7_ADD) || (funct7 == F7_SUB));
      dec_o.is_sub  = dec_o.is_r && (funct7 == F7_SUB);
      dec_o.is_addi = (opcode == OP_IMM)    && (funct3 == F3_ADD);
      dec_o.is_lw   = (opcode == OP_LOAD)   && (funct3 == F3_LW);
      dec_o.is_sw   = (opcode == OP_STORE)  && (funct3 == F3_SW);
      dec_o.is_beq  = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
      dec_o.is_bne  = (opcode == OP_BRANCH) && (funct3 == F3_BNE);
      dec_o.legal   = dec_o.is_r | dec_o.is_addi | dec_o.is_lw |
                      dec_o.is_sw | dec_o.is_beq | dec_o.is_bne;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencing controller for the multi-cycle RV32I datapath (FETCH/DECODE/EXECUTE/MEM/WB/TRAP).
// Latency: alu ops 4, lw 5, sw 4, branch 3 cycles with zero-wait memory; +1 per mem_ready=0 cycle.
// Backpressure: holds in FETCH/MEM while mem_ready=0. Perf counters built only with CTRL_PERF_CNT_EN.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int INSTR_WIDTH = 32,
   parameter int CNT_WIDTH   = 32
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic                   mem_ready,
   input  logic                   EQ,
   output logic                   mem_req,
   output logic                   MemWrite,
   output logic                   IR_en,
   output logic                   PC_en,
   output logic                   PCsrc,
   output logic                   ALUctrl,
   output logic                   ALUsrc,
   output logic [1:0]             ImmSrc,
   output logic                   RegWrite,
   output logic                   ResultSrc,
   output logic                   illegal,
   output logic [CNT_WIDTH-1:0]   retire_cnt,
   output logic [CNT_WIDTH-1:0]   cycle_cnt
);

   state_t                 state_q, state_d;
   logic [INSTR_WIDTH-1:0] ir_q, ir_d;
   dec_t                   dec;

   ctrl_decode u_decode (
      .ir_i  (ir_q[31:0]),
      .dec_o (dec)
   );

   assign ir_d = IR_en ? instr : ir_q;

   // State and IR copy; async reset parks the FSM in FETCH with a cleared IR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Next state and Moore outputs; gated by rst_n so an in-flight access drops at once
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      IR_en     = 1'b0;
      PC_en     = 1'b0;
      PCsrc     = 1'b0;
      ALUctrl   = 1'b0;
      ALUsrc    = 1'b0;
      ImmSrc    = IMM_I;
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      illegal   = 1'b0;
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               IR_en   = mem_ready;
               if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
               state_d = dec.legal ? EXECUTE : TRAP;
            end
            EXECUTE: begin
               ALUctrl = dec.is_sub | dec.is_beq | dec.is_bne;
               ALUsrc  = dec.is_addi | dec.is_lw | dec.is_sw;
               if (dec.is_sw)
                  ImmSrc = IMM_S;
               else if (dec.is_beq | dec.is_bne)
                  ImmSrc = IMM_B;
               if (dec.is_beq | dec.is_bne) begin
                  // Only output that looks at a live input besides mem_ready
                  PC_en   = 1'b1;
                  PCsrc   = (dec.is_beq & EQ) | (dec.is_bne & ~EQ);
                  state_d = FETCH;
               end else if (dec.is_lw | dec.is_sw) begin
                  state_d = MEM;
               end else begin
                  state_d = WB;
               end
            end
            MEM: begin
               mem_req  = 1'b1;
               MemWrite = dec.is_sw;
               if (mem_ready) begin
                  if (dec.is_sw) begin
                     PC_en   = 1'b1;
                     state_d = FETCH;
                  end else begin
                     state_d = WB;
                  end
               end
            end
            WB: begin
               RegWrite  = 1'b1;
               ResultSrc = dec.is_lw;
               PC_en     = 1'b1;
               state_d   = FETCH;
            end
            TRAP: begin
               illegal = 1'b1;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

   assign cycle_cnt_d  = cycle_cnt_q + CNT_ONE;
   assign retire_cnt_d = PC_en ? (retire_cnt_q + CNT_ONE) : retire_cnt_q;

   // Free-running counters; each PC_en pulse marks exactly one retired instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;
`else
   assign cycle_cnt  = '0;
   assign retire_cnt = '0;
`endif

endmodule
